// File: rtl/period_stb_gen.sv
// Period-measuring strobe generator: averages the sig_i period over 2**AVG_LOG2 edges,
// then free-runs a strobe at that period aligned to a later sig_i edge, with loss-of-signal detection.
module period_stb_gen #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1048576,
    parameter int unsigned MIN_PERIOD  = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             oe_i,
    input  logic [CNT_W-1:0] phase_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             stb_o,
    output logic             rdy_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] period_o
);

    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned EC_W  = AVG_LOG2 + 1;
    localparam int unsigned NAVG  = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        CHECK   = 3'd3,
        ALIGN   = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_t;

    state_t                 state_r, state_n;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r, rise_q_r;
    logic [ACC_W-1:0]       acc_r, acc_p1_s;
    logic [EC_W-1:0]        ecnt_r;
    logic [CNT_W-1:0]       gap_r, period_r, phase_r, width_r, ph_r, per_s;
    logic                   first_r, stb_r, rdy_r, busy_r, err_r;
    logic                   bad_s, tmo_s, active_s, in_win_s, stb_int_s;
    logic [CNT_W:0]         end_s, per_x_s, ph_x_s;

    // sig_i synchroniser and registered rising-edge detect
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            sync_r   <= '0;
            prev_r   <= 1'b0;
            rise_q_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_i};
            prev_r   <= sync_r[SYNC_STAGES-1];
            rise_q_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign acc_p1_s = acc_r + ACC_W'(1);
    assign per_s    = CNT_W'(acc_p1_s >> AVG_LOG2);
    assign bad_s    = (per_s < CNT_W'(MIN_PERIOD)) || (width_i == '0) ||
                      (width_i >= per_s) || (phase_i >= per_s);
    assign active_s = (state_r == ARM) || (state_r == MEASURE) ||
                      (state_r == ALIGN) || (state_r == RUN);
    assign tmo_s    = active_s && !rise_q_r && (gap_r == CNT_W'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // next-state decode; start_i outranks timeout
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE, ERR: begin
                if (start_i) state_n = ARM;
                else         state_n = state_r;
            end
            default: begin
                if (start_i)    state_n = ARM;
                else if (tmo_s) state_n = ERR;
                else begin
                    case (state_r)
                        ARM:     state_n = rise_q_r ? MEASURE : ARM;
                        MEASURE: state_n = (rise_q_r && (ecnt_r == EC_W'(NAVG - 1))) ? CHECK : MEASURE;
                        CHECK:   state_n = bad_s ? ERR : ALIGN;
                        ALIGN:   state_n = rise_q_r ? RUN : ALIGN;
                        RUN:     state_n = RUN;
                        default: state_n = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Strobe window; the wrapped tail is suppressed until ph first wraps so the first pulse starts at phase
    always_comb begin
        end_s   = {1'b0, phase_r} + {1'b0, width_r};
        per_x_s = {1'b0, period_r};
        ph_x_s  = {1'b0, ph_r};
        if (end_s <= per_x_s) begin
            in_win_s = (ph_r >= phase_r) && (ph_x_s < end_s);
        end else begin
            in_win_s = (ph_r >= phase_r) || (!first_r && (ph_x_s < (end_s - per_x_s)));
        end
        stb_int_s = (state_r == RUN) && in_win_s;
    end

    // measurement, phase counter and registered outputs
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            acc_r    <= '0;
            ecnt_r   <= '0;
            gap_r    <= '0;
            period_r <= '0;
            phase_r  <= '0;
            width_r  <= '0;
            ph_r     <= '0;
            first_r  <= 1'b0;
            stb_r    <= 1'b0;
            rdy_r    <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if ((state_r == IDLE) || (state_r == ERR) || start_i || rise_q_r) begin
                gap_r <= '0;
            end else begin
                gap_r <= gap_r + CNT_W'(1);
            end

            if ((state_r == ARM) && (state_n == MEASURE)) begin
                acc_r  <= '0;
                ecnt_r <= '0;
            end else if ((state_r == MEASURE) && (state_n == MEASURE)) begin
                acc_r <= acc_p1_s;
                if (rise_q_r) ecnt_r <= ecnt_r + EC_W'(1);
                else          ecnt_r <= ecnt_r;
            end else begin
                acc_r  <= acc_r;
                ecnt_r <= ecnt_r;
            end

            if (state_r == CHECK) begin
                period_r <= per_s;
                phase_r  <= phase_i;
                width_r  <= width_i;
            end

            if ((state_r == ALIGN) && (state_n == RUN)) begin
                ph_r    <= '0;
                first_r <= 1'b1;
            end else if (state_r == RUN) begin
                if (ph_r == (period_r - CNT_W'(1))) begin
                    ph_r    <= '0;
                    first_r <= 1'b0;
                end else begin
                    ph_r <= ph_r + CNT_W'(1);
                end
            end

            stb_r  <= stb_int_s && oe_i && (state_n == RUN);
            rdy_r  <= (state_n == RUN);
            busy_r <= (state_n == ARM) || (state_n == MEASURE) ||
                      (state_n == CHECK) || (state_n == ALIGN);
            err_r  <= (state_n == ERR);
        end
    end

    assign stb_o    = stb_r;
    assign rdy_o    = rdy_r;
    assign busy_o   = busy_r;
    assign err_o    = err_r;
    assign period_o = period_r;

endmodule

// File: tb/tb_period_stb_gen.sv
// Scoreboard bench for period_stb_gen: stimulus queues expected events, a monitor
// turns DUT output transitions into events and compares them in order.
module tb_period_stb_gen;

    logic        clk = 1'b0;
    logic        arst_i = 1'b0;
    logic        sig_i = 1'b0;
    logic        start_i = 1'b0;
    logic        oe_i = 1'b0;
    logic [31:0] phase_i = 32'd0;
    logic [31:0] width_i = 32'd0;
    logic        stb_o, rdy_o, busy_o, err_o;
    logic [31:0] period_o;

    always #5 clk = ~clk;

    period_stb_gen #(
        .CNT_W(32), .AVG_LOG2(2), .SYNC_STAGES(2), .TIMEOUT(64), .MIN_PERIOD(8)
    ) dut (
        .clk_i(clk), .arst_i(arst_i), .sig_i(sig_i), .start_i(start_i), .oe_i(oe_i),
        .phase_i(phase_i), .width_i(width_i), .stb_o(stb_o), .rdy_o(rdy_o),
        .busy_o(busy_o), .err_o(err_o), .period_o(period_o)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   align_c0 = 0;
    bit   sig_run = 1'b0;
    int   pat[4] = '{10, 10, 10, 10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input string t, input int v);
        exp_q.push_back('{tag: t, val: v});
    endtask

    task automatic evt(input string t, input int v);
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].tag == t) begin
            e = exp_q.pop_front();
            chk({"evt_", t}, v, e.val);
        end else if (t == "PER" || t == "ERR" || t == "RISE") begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_%s: got %0d, expected no such event (cycle %0d)", t, v, cyc);
        end
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        while (exp_q.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL pending_%s: got no event, expected %0d", exp_q[0].tag, exp_q[0].val);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic sig_go(input int p0, input int p1, input int p2, input int p3);
        pat = '{p0, p1, p2, p3};
        sig_run = 1'b1;
    endtask

    task automatic sig_stop();
        sig_run = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // sig_i generator: 3-cycle high pulses, periods from pat; rise #6 is the aligning edge
    initial begin
        int pc = 0;
        int k = 0;
        int cur = 10;
        forever begin
            @(negedge clk);
            if (!sig_run) begin
                sig_i = 1'b0;
                pc = 0;
                k = 0;
            end else if (pc == 0) begin
                sig_i = 1'b1;
                k++;
                cur = pat[(k - 1) % 4];
                if (k == 6) align_c0 = cyc;
                pc = 1;
            end else begin
                if (pc == 3) sig_i = 1'b0;
                pc = (pc + 1 == cur) ? 0 : pc + 1;
            end
        end
    end

    // monitor: output transitions -> scoreboard events
    initial begin
        bit p_rdy = 1'b0, p_err = 1'b0, p_stb = 1'b0, want_rise = 1'b0;
        int hi = 0;
        int last_rise = 0;
        forever begin
            @(negedge clk);
            if (!arst_i) begin
                p_rdy = 1'b0; p_err = 1'b0; p_stb = 1'b0; want_rise = 1'b0; hi = 0;
            end else begin
                if (rdy_o && !p_rdy) begin
                    evt("PER", int'(period_o));
                    want_rise = 1'b1;
                end
                if (!rdy_o) want_rise = 1'b0;
                if (err_o && !p_err) evt("ERR", int'(period_o));
                if (stb_o && !p_stb) begin
                    if (want_rise) evt("RISE", cyc - align_c0);
                    else           evt("PRD", cyc - last_rise);
                    want_rise = 1'b0;
                    last_rise = cyc;
                    hi = 0;
                end
                if (stb_o) hi++;
                if (!stb_o && p_stb) evt("WID", hi);
                p_rdy = rdy_o; p_err = err_o; p_stb = stb_o;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int lost;
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_stb", int'(stb_o), 0);
        chk("rst_rdy", int'(rdy_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_period", int'(period_o), 0);
        arst_i = 1'b1;
        repeat (2) @(negedge clk);

        // 1: period 10, phase 3, width 2
        oe_i = 1'b1; phase_i = 32'd3; width_i = 32'd2;
        do_start();
        chk("arm_busy", int'(busy_o), 1);
        sig_go(10, 10, 10, 10);
        push("PER", 10); push("RISE", 8); push("WID", 2); push("PRD", 10); push("WID", 2);
        wait_empty(400);
        chk("t1_rdy", int'(rdy_o), 1);
        chk("t1_busy", int'(busy_o), 0);

        // 2: wrapped window phase 8, width 4
        push("ERR", 10);
        sig_stop();
        wait_empty(300);
        phase_i = 32'd8; width_i = 32'd4;
        do_start();
        sig_go(10, 10, 10, 10);
        push("PER", 10); push("RISE", 13); push("WID", 4); push("PRD", 10); push("WID", 4);
        wait_empty(400);

        // 3: alternating 10/11 periods average to 10
        push("ERR", 10);
        sig_stop();
        wait_empty(300);
        phase_i = 32'd3; width_i = 32'd2;
        do_start();
        sig_go(10, 11, 10, 11);
        push("PER", 10); push("RISE", 8);
        wait_empty(400);

        // 4: width equal to period is rejected, then recovery
        push("ERR", 10);
        sig_stop();
        wait_empty(300);
        width_i = 32'd10;
        do_start();
        sig_go(10, 10, 10, 10);
        push("ERR", 10);
        wait_empty(400);
        chk("t4_rdy", int'(rdy_o), 0);
        chk("t4_err", int'(err_o), 1);
        sig_stop();
        width_i = 32'd2;
        do_start();
        chk("t4_err_clr", int'(err_o), 0);
        sig_go(10, 10, 10, 10);
        push("PER", 10); push("RISE", 8); push("WID", 2);
        wait_empty(400);

        // 5: loss of signal in RUN, then timeout from ARM
        push("ERR", 10);
        sig_stop();
        wait_empty(300);
        chk("t5_stb", int'(stb_o), 0);
        chk("t5_err", int'(err_o), 1);
        chk("t5_rdy", int'(rdy_o), 0);
        push("ERR", 10);
        do_start();
        repeat (63) @(negedge clk);
        chk("tmo_63", int'(err_o), 0);
        @(negedge clk);
        chk("tmo_64", int'(err_o), 1);
        wait_empty(20);

        // 6: oe_i masking, start in RUN, async reset in RUN
        oe_i = 1'b0; phase_i = 32'd3; width_i = 32'd2;
        do_start();
        sig_go(10, 10, 10, 10);
        push("PER", 10);
        wait_empty(400);
        hi_cnt = 0;
        lost = 0;
        repeat (30) begin
            @(negedge clk);
            if (stb_o) hi_cnt++;
            if (!rdy_o) lost++;
        end
        chk("oe_mask_stb", hi_cnt, 0);
        chk("oe_rdy_hold", lost, 0);
        do_start();
        chk("rst_run_rdy", int'(rdy_o), 0);
        chk("rst_run_stb", int'(stb_o), 0);
        chk("rst_run_busy", int'(busy_o), 1);
        push("PER", 10);
        wait_empty(400);
        @(negedge clk);
        arst_i = 1'b0;
        #1;
        chk("arst_stb", int'(stb_o), 0);
        chk("arst_rdy", int'(rdy_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_err", int'(err_o), 0);
        chk("arst_period", int'(period_o), 0);
        sig_stop();
        arst_i = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
